rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameters SHALL be:
- N_OUT, 3: number of sequenced reset outputs, 1..8.
- STRETCH_W, 16: width of the stretch/gap counter.
- STRETCH, 16'hFFFF: hold cycles before the first release, 1..2^STRETCH_W-1.
- GAP, 16: cycles between consecutive releases, 1..2^STRETCH_W-1.
- SYNC_STAGES, 2: reset synchronizer depth, 2..4.
- TRAP_RST, 1: trap rising edge triggers a reset when 1.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; sole clock.
- rst_n  in  1  external reset, asynchronous, active-low.
- sw_rst_req  in  1  software reset request, single-cycle pulse.
- trap  in  1  CPU trap flag, level.
- rst_out  out  N_OUT  sequenced resets, active-high; bit 0 released first.
- rst_done  out  1  high when every rst_out bit is released.
- busy  out  1  high while the sequencer is outside RUN.
- rst_cause  out  2  last reset cause: 00 external, 01 software, 10 trap.

Function
REQ-003 rst_n SHALL pass through rst_sync: asynchronous assertion, deassertion synchronized over SYNC_STAGES flops.
REQ-004 FSM states SHALL be ASSERT, RELEASE and RUN; synchronized reset active forces ASSERT.
REQ-005 ASSERT SHALL load the counter with STRETCH-1, decrement each cycle and go to RELEASE at 0, with all rst_out bits at 1.
REQ-006 RELEASE SHALL clear rst_out[0] on entry, then clear rst_out[k] GAP cycles after rst_out[k-1], and go to RUN in the cycle rst_out[N_OUT-1] clears.
REQ-007 rst_out[0] SHALL deassert exactly SYNC_STAGES+STRETCH rising edges after the first edge that samples rst_n high.
REQ-008 rst_done SHALL be registered and rise in the same cycle as rst_out[N_OUT-1] falls; busy SHALL equal !rst_done.
REQ-009 In RUN, sw_rst_req=1 SHALL, on the next edge, set every rst_out bit, clear rst_done, set rst_cause=01 and enter ASSERT.
REQ-010 With TRAP_RST=1, a rising edge on trap in RUN SHALL act as in REQ-009 with rst_cause=10; a held trap SHALL NOT retrigger; with TRAP_RST=0, trap SHALL be ignored.
REQ-011 sw_rst_req in RELEASE SHALL reassert all rst_out bits and restart ASSERT; in ASSERT it SHALL be ignored and the count SHALL continue.
REQ-012 Simultaneous sw_rst_req and trap edge SHALL record cause 01.
REQ-013 The counter SHALL never wrap; N_OUT=1 SHALL enter RUN on the RELEASE entry cycle.

Reset
REQ-014 While rst_n is low or the synchronizer is active: rst_out all 1, rst_done 0, busy 1, rst_cause 00, state ASSERT, counter STRETCH-1, trap edge register 0.
REQ-015 rst_n asserting mid-sequence or in RUN SHALL take effect asynchronously, overriding any pending software or trap request.

Structure
REQ-016 Package rst_seq_pkg SHALL hold the state encoding and the cause codes (CAUSE_EXT, CAUSE_SW, CAUSE_TRAP).
REQ-017 Sub-module rst_sync (parameter SYNC_STAGES) SHALL implement REQ-003; the top level instantiates rst_seq with rst_out[0] driving system rst.

Verification (N_OUT=3, STRETCH=8, GAP=4, SYNC_STAGES=2)
REQ-018 Release rst_n at edge 0 -> rst_out falls bit by bit at edges 10, 14, 18; rst_done=1 at edge 18; cause=00.
REQ-019 sw_rst_req pulse in RUN -> next edge rst_out=3'b111, busy=1; releases at +9/+13/+17 edges; cause=01.
REQ-020 trap held high for 50 cycles in RUN -> exactly one reset sequence, cause=10; with TRAP_RST=0 -> none.
REQ-021 sw_rst_req at edge 12 (mid-RELEASE) -> rst_out back to 3'b111 at edge 13; full sequence restarts.
REQ-022 rst_n low at edge 15 -> rst_out=3'b111 before the next edge; cause=00; resequence on release.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg -- shared definitions for the reset sequencer.
//   state_t : sequencer states (hold all resets, staggered release, running)
//   cause_t : encoding of the last reset cause reported on rst_cause
//   IDX_W   : width of the "next output to release" index (covers N_OUT up to 8)
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_EXT  = 2'b00,
    CAUSE_SW   = 2'b01,
    CAUSE_TRAP = 2'b10
  } cause_t;

  localparam int IDX_W = 3;

endpackage

// File: rtl/rst_sync.sv
// rst_sync -- reset synchronizer: asserts asynchronously with rst_n, releases
// synchronously after SYNC_STAGES rising edges of clk.
//   clk        in   system clock
//   rst_n      in   raw external reset, active-low, asynchronous
//   rst_n_sync out  synchronized reset, active-low
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // A constant 1 is shifted in; the last stage only goes high once every
  // stage has seen rst_n high, which filters metastability on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq -- reset sequencer. Holds N_OUT active-high resets for STRETCH
// cycles after the (synchronized) external reset, then releases them one by
// one, GAP cycles apart, bit 0 first. Software requests and trap rising edges
// re-run the sequence; rst_cause records why the last reset happened.
// rst_out[0] is intended to drive the system-level reset.
//   clk        in   system clock
//   rst_n      in   external reset, asynchronous, active-low
//   sw_rst_req in   software reset request, single-cycle pulse
//   trap       in   CPU trap flag, level
//   rst_out    out  sequenced resets, active-high, bit 0 released first
//   rst_done   out  all rst_out bits released
//   busy       out  sequencer not in RUN (inverse of rst_done)
//   rst_cause  out  last reset cause (00 external, 01 software, 10 trap)
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int STRETCH_W   = 16,
  parameter int STRETCH     = 16'hFFFF,
  parameter int GAP         = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit TRAP_RST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             trap,
  output logic [N_OUT-1:0] rst_out,
  output logic             rst_done,
  output logic             busy,
  output logic [1:0]       rst_cause
);

  localparam logic [STRETCH_W-1:0] CNT_STRETCH = STRETCH_W'(STRETCH - 1);
  localparam logic [STRETCH_W-1:0] CNT_GAP     = STRETCH_W'(GAP - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_OUT - 1);

  logic rst_n_sync;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_n_sync(rst_n_sync)
  );

  state_t                 state_reg, state_next;
  logic [STRETCH_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [N_OUT-1:0]       rst_out_reg, rst_out_next;
  logic                   done_reg, done_next;
  cause_t                 cause_reg, cause_next;
  logic                   trap_q_reg;
  logic                   trap_edge;

  // trap_q_reg follows trap in every state, so a trap that rose earlier and
  // is still held never looks like a fresh edge once RUN is reached.
  assign trap_edge = TRAP_RST && trap && !trap_q_reg;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_reg   <= ST_ASSERT;
      cnt_reg     <= CNT_STRETCH;
      idx_reg     <= '0;
      rst_out_reg <= '1;
      done_reg    <= 1'b0;
      cause_reg   <= CAUSE_EXT;
      trap_q_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      rst_out_reg <= rst_out_next;
      done_reg    <= done_next;
      cause_reg   <= cause_next;
      trap_q_reg  <= trap;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    rst_out_next = rst_out_reg;
    done_next    = done_reg;
    cause_next   = cause_reg;

    unique case (state_reg)
      ST_ASSERT: begin
        // Software requests are deliberately ignored here: the stretch runs out.
        if (cnt_reg == '0) begin
          // Enter RELEASE with the gap counter already expired so bit 0
          // drops at the end of the first RELEASE cycle.
          state_next = ST_RELEASE;
          idx_next   = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_RELEASE: begin
        if (sw_rst_req) begin
          state_next   = ST_ASSERT;
          cnt_next     = CNT_STRETCH;
          rst_out_next = '1;
          done_next    = 1'b0;
          cause_next   = CAUSE_SW;
        end else if (cnt_reg == '0) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (idx_reg == IDX_W'(i)) begin
              rst_out_next[i] = 1'b0;
            end
          end
          if (idx_reg == LAST_IDX) begin
            state_next = ST_RUN;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
            cnt_next = CNT_GAP;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_RUN: begin
        // Software wins over a simultaneous trap edge when recording the cause.
        if (sw_rst_req || trap_edge) begin
          state_next   = ST_ASSERT;
          cnt_next     = CNT_STRETCH;
          rst_out_next = '1;
          done_next    = 1'b0;
          cause_next   = sw_rst_req ? CAUSE_SW : CAUSE_TRAP;
        end
      end

      default: begin
        state_next   = ST_ASSERT;
        cnt_next     = CNT_STRETCH;
        rst_out_next = '1;
        done_next    = 1'b0;
      end
    endcase
  end

  assign rst_out   = rst_out_reg;
  assign rst_done  = done_reg;
  assign busy      = !done_reg;
  assign rst_cause = cause_reg;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq -- scoreboard bench for rst_seq (N_OUT=3, STRETCH=8, GAP=4,
// SYNC_STAGES=2). Each stimulus pushes the output changes it should cause;
// a monitor applies them at their due cycle and compares every cycle.
// A second instance with TRAP_RST=0 must ignore the held trap.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int N_OUT   = 3;
  localparam int STRETCH = 8;
  localparam int GAP     = 4;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       trap = 1'b0;
  logic [2:0] rst_out, rst_out_nt;
  logic       rst_done, done_nt, busy, busy_nt;
  logic [1:0] rst_cause, cause_nt;

  rst_seq #(
    .N_OUT(N_OUT), .STRETCH_W(16), .STRETCH(STRETCH), .GAP(GAP),
    .SYNC_STAGES(SYNC), .TRAP_RST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .trap(trap),
    .rst_out(rst_out), .rst_done(rst_done), .busy(busy), .rst_cause(rst_cause)
  );

  rst_seq #(
    .N_OUT(N_OUT), .STRETCH_W(16), .STRETCH(STRETCH), .GAP(GAP),
    .SYNC_STAGES(SYNC), .TRAP_RST(1'b0)
  ) dut_nt (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .trap(trap),
    .rst_out(rst_out_nt), .rst_done(done_nt), .busy(busy_nt), .rst_cause(cause_nt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] ro;
    logic       done;
    logic [1:0] cause;
  } ev_t;

  ev_t        sb[$];
  ev_t        ev;
  int         total = 0;
  int         bad = 0;
  int         cyc = -1;
  logic [2:0] exp_ro = 3'b111;
  logic       exp_done = 1'b0;
  logic [1:0] exp_cause = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_ev(input int at, input logic [2:0] ro, input logic done,
                         input logic [1:0] cause);
    ev_t e;
    e.at = at; e.ro = ro; e.done = done; e.cause = cause;
    sb.push_back(e);
  endtask

  // e is the edge at which the outputs are (re)asserted. First release at
  // e+STRETCH+1, further ones GAP apart; rst_done with the last.
  task automatic push_seq(input int e, input logic [1:0] cause, input bit restart);
    logic [2:0] ones;
    ones = 3'b111;
    if (restart) push_ev(e, 3'b111, 1'b0, cause);
    for (int k = 0; k < N_OUT; k++) begin
      push_ev(e + STRETCH + 1 + k * GAP, ones << (k + 1), (k == N_OUT - 1), cause);
    end
  endtask

  task automatic flush_after(input int k);
    while (sb.size() > 0 && sb[$].at > k) sb.delete(sb.size() - 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // rst_n rises now; the first edge sampling it is cyc+1, so the sequence
  // behaves like a restart at edge cyc+SYNC.
  task automatic release_rst();
    rst_n = 1'b1;
    flush_after(cyc);
    push_seq(cyc + SYNC, CAUSE_EXT, 1'b0);
  endtask

  task automatic assert_rst();
    rst_n = 1'b0;
    sb.delete();
    push_ev(cyc, 3'b111, 1'b0, CAUSE_EXT);
    #1;
    check("async_rst_out", 32'(rst_out), 32'(3'b111));
    check("async_done", 32'(rst_done), 32'(1'b0));
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    flush_after(cyc);
    push_seq(cyc + 1, CAUSE_SW, 1'b1);
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  task automatic sw_ignored();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  // Monitor: edge count at posedge, compare at the following negedge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        ev = sb.pop_front();
        exp_ro    = ev.ro;
        exp_done  = ev.done;
        exp_cause = ev.cause;
        $display("cyc=%0d expect rst_out=%b done=%b cause=%b", cyc, exp_ro, exp_done, exp_cause);
      end
      check("rst_out", 32'(rst_out), 32'(exp_ro));
      check("rst_done", 32'(rst_done), 32'(exp_done));
      check("busy", 32'(busy), 32'(!exp_done));
      check("rst_cause", 32'(rst_cause), 32'(exp_cause));
    end
  end

  initial begin
    // Power-on reset, then release.
    tick(3);
    release_rst();
    tick(25);

    // Software reset from RUN.
    sw_pulse();
    tick(25);

    // Software request during ASSERT is ignored.
    sw_pulse();
    tick(3);
    sw_ignored();
    tick(25);

    // Software request between first and second release restarts everything.
    sw_pulse();
    tick(11);
    sw_pulse();
    tick(25);

    // Trap held for 50 cycles: one sequence only; TRAP_RST=0 instance untouched.
    trap = 1'b1;
    flush_after(cyc);
    push_seq(cyc + 1, CAUSE_TRAP, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("nt_rst_out", 32'(rst_out_nt), 32'(3'b000));
      check("nt_done", 32'(done_nt), 32'(1'b1));
      check("nt_busy", 32'(busy_nt), 32'(1'b0));
    end
    trap = 1'b0;
    tick(25);

    // Simultaneous software request and trap edge: software cause wins.
    sw_rst_req = 1'b1;
    trap = 1'b1;
    flush_after(cyc);
    push_seq(cyc + 1, CAUSE_SW, 1'b1);
    tick(1);
    sw_rst_req = 1'b0;
    tick(25);
    trap = 1'b0;
    tick(3);

    // External reset in the middle of RELEASE, then resequence.
    sw_pulse();
    tick(14);
    assert_rst();
    tick(3);
    release_rst();
    tick(25);

    check("sb_empty", 32'(sb.size()), 32'(0));
    check("nt_cause", 32'(cause_nt), 32'(CAUSE_EXT));
    check("nt_final_done", 32'(done_nt), 32'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
